// File: rtl/arm_pkg.sv
// Shared constants and helpers for the ARM fetch stage.
// Contents:
//   WORD_W           - datapath / address width
//   PC_INC           - sequential fetch increment
//   NOP_INSTR_DEF    - bubble word (MOV r0,r0) placed in decode on flush or miss
//   RESET_PC_DEF     - default PC after reset
//   pc_plus4()       - modulo-2^32 sequential PC increment
package arm_pkg;

    localparam int                  WORD_W        = 32;
    localparam logic [WORD_W-1:0]   PC_INC        = 32'd4;
    localparam logic [WORD_W-1:0]   NOP_INSTR_DEF = 32'hE1A0_0000;
    localparam logic [WORD_W-1:0]   RESET_PC_DEF  = 32'h0000_0000;

    // Wraps silently at 2^32; no carry is reported.
    function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/arm_fetch_stage_if.sv
// Signal bundle between the fetch stage and its surroundings
// (instruction memory, hazard unit, Execute/Writeback redirects, decode).
// Modports:
//   master - the fetch stage itself (drives PCF and the decode-side outputs)
//   slave  - the environment (drives instruction data, stalls, flushes, redirects)
interface arm_fetch_stage_if;
    import arm_pkg::*;

    logic [WORD_W-1:0] PCF;
    logic [WORD_W-1:0] InstrF;
    logic              ImemReady;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              BranchTakenE;
    logic [WORD_W-1:0] ALUResultE;
    logic              PCSrcW;
    logic [WORD_W-1:0] ResultW;
    logic [WORD_W-1:0] InstrD;
    logic [WORD_W-1:0] PCPlus8D;
    logic              ValidD;
    logic [WORD_W-1:0] FetchCount;
    logic [WORD_W-1:0] StallCount;

    modport master (
        output PCF, InstrD, PCPlus8D, ValidD, FetchCount, StallCount,
        input  InstrF, ImemReady, StallF, StallD, FlushD,
               BranchTakenE, ALUResultE, PCSrcW, ResultW
    );

    modport slave (
        input  PCF, InstrD, PCPlus8D, ValidD, FetchCount, StallCount,
        output InstrF, ImemReady, StallF, StallD, FlushD,
               BranchTakenE, ALUResultE, PCSrcW, ResultW
    );

endinterface

// File: rtl/arm_fd_reg.sv
// Enable/clear pipeline register used for each field of the F/D register.
// Ports:
//   clk, reset - core clock, synchronous active-high reset
//   clr        - load CLR_VAL (wins over en)
//   en         - load d
//   d / q      - DATA_W-bit data in / registered out
// Reset loads the same value as clr, so each instance has one "empty" value.
module arm_fd_reg #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/arm_fetch_stage.sv
// Fetch stage and F/D pipeline register of the pipelined ARM core.
// Owns the PC, drives the instruction-memory address and captures the fetched
// word into decode, honouring stalls, flushes and branch/writeback redirects.
// Ports:
//   clk, reset - core clock, synchronous active-high reset
//   bus        - arm_fetch_stage_if.master: PCF/InstrF/ImemReady (imem),
//                StallF/StallD/FlushD (hazard), BranchTakenE/ALUResultE,
//                PCSrcW/ResultW (redirects), InstrD/PCPlus8D/ValidD (decode),
//                FetchCount/StallCount (performance counters)
// Build option: define ARM_FETCH_PERF_EN to generate the performance counters;
// otherwise FetchCount and StallCount read 0 and no counter flops exist.
module arm_fetch_stage
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                clk,
    input  logic                reset,
    arm_fetch_stage_if.master   bus
);

    logic              redirect;
    logic [WORD_W-1:0] pc_f;
    logic [WORD_W-1:0] pc_plus4_f;
    logic [WORD_W-1:0] pc_next;
    logic              fd_clr;
    logic              instr_clr;
    logic              p8_en;

    assign redirect   = bus.BranchTakenE | bus.PCSrcW;
    assign pc_plus4_f = pc_plus4(pc_f);

    // Redirect targets are taken verbatim (no alignment masking) and beat any hold.
    always_comb begin
        pc_next = pc_plus4_f;
        if (bus.BranchTakenE) begin
            pc_next = bus.ALUResultE;
        end else if (bus.PCSrcW) begin
            pc_next = bus.ResultW;
        end else if (bus.StallF || !bus.ImemReady) begin
            pc_next = pc_f;
        end
    end

    // ---- Fetch stage: PC register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f <= RESET_PC;
        end else begin
            pc_f <= pc_next;
        end
    end

    assign bus.PCF = pc_f;

    // A redirect kills whatever was fetched on the wrong path this cycle.
    assign fd_clr    = bus.FlushD | redirect;
    // An imem miss inserts a bubble but leaves PCPlus8D alone.
    assign instr_clr = fd_clr | (!bus.StallD & !bus.ImemReady);
    assign p8_en     = !bus.StallD & bus.ImemReady;

    // ---- F/D register ----
    arm_fd_reg #(.DATA_W(WORD_W), .CLR_VAL(NOP_INSTR)) u_instr_d (
        .clk   (clk),
        .reset (reset),
        .clr   (instr_clr),
        .en    (!bus.StallD),
        .d     (bus.InstrF),
        .q     (bus.InstrD)
    );

    arm_fd_reg #(.DATA_W(WORD_W), .CLR_VAL('0)) u_pcplus8_d (
        .clk   (clk),
        .reset (reset),
        .clr   (fd_clr),
        .en    (p8_en),
        .d     (pc_plus4_f),
        .q     (bus.PCPlus8D)
    );

    arm_fd_reg #(.DATA_W(1), .CLR_VAL(1'b0)) u_valid_d (
        .clk   (clk),
        .reset (reset),
        .clr   (instr_clr),
        .en    (!bus.StallD),
        .d     (1'b1),
        .q     (bus.ValidD)
    );

`ifdef ARM_FETCH_PERF_EN
    logic              fd_load_valid;
    logic              stall_cyc;
    logic [WORD_W-1:0] fetch_cnt;
    logic [WORD_W-1:0] stall_cnt;

    assign fd_load_valid = !fd_clr & !bus.StallD & bus.ImemReady;
    assign stall_cyc     = (bus.StallF | !bus.ImemReady) & !redirect;

    // ---- Performance counters ----
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fd_load_valid) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (stall_cyc) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign bus.FetchCount = fetch_cnt;
    assign bus.StallCount = stall_cnt;
`else
    assign bus.FetchCount = '0;
    assign bus.StallCount = '0;
`endif

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Self-checking bench for arm_fetch_stage: a cycle model predicts the next
// register state from the inputs driven each cycle, pushes it to a scoreboard
// queue, and the prediction is popped and compared after the clock edge.
// Directed checks cover the reset state, redirects, stalls, imem misses,
// PC wrap-around and the performance counters.
module tb_arm_fetch_stage;
    import arm_pkg::*;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p8;
        logic        vld;
        logic [31:0] fc;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_fetch_stage_if bus ();

    arm_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sbq[$];
    exp_t m;
    int   checks   = 0;
    int   failures = 0;
    logic use_const;
    logic [31:0] held_instr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        return 32'hE280_0000 | {16'h0, pc[15:0]};
    endfunction

    task automatic idle();
        bus.ImemReady    = 1'b1;
        bus.StallF       = 1'b0;
        bus.StallD       = 1'b0;
        bus.FlushD       = 1'b0;
        bus.BranchTakenE = 1'b0;
        bus.ALUResultE   = 32'h0;
        bus.PCSrcW       = 1'b0;
        bus.ResultW      = 32'h0;
    endtask

    // One clock: predict, push, clock, pop, compare.
    task automatic cycle();
        exp_t        n;
        exp_t        e;
        logic        redir;
        logic [31:0] p4;
        bus.InstrF = use_const ? 32'hE280_0001 : instr_at(m.pc);
        n     = m;
        p4    = m.pc + 32'd4;
        redir = bus.BranchTakenE | bus.PCSrcW;
        if (reset) begin
            n.pc = 32'h0; n.instr = NOP; n.p8 = 32'h0; n.vld = 1'b0;
            n.fc = 32'h0; n.sc = 32'h0;
        end else begin
            if (bus.BranchTakenE)                    n.pc = bus.ALUResultE;
            else if (bus.PCSrcW)                     n.pc = bus.ResultW;
            else if (bus.StallF || !bus.ImemReady)   n.pc = m.pc;
            else                                     n.pc = p4;
            if (bus.FlushD || redir) begin
                n.instr = NOP; n.vld = 1'b0; n.p8 = 32'h0;
            end else if (bus.StallD) begin
                n.instr = m.instr;
            end else if (!bus.ImemReady) begin
                n.instr = NOP; n.vld = 1'b0;
            end else begin
                n.instr = bus.InstrF; n.p8 = p4; n.vld = 1'b1;
            end
`ifdef ARM_FETCH_PERF_EN
            if (!bus.FlushD && !redir && !bus.StallD && bus.ImemReady) n.fc = m.fc + 32'd1;
            if ((bus.StallF || !bus.ImemReady) && !redir)               n.sc = m.sc + 32'd1;
`endif
        end
        sbq.push_back(n);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_pcf",      bus.PCF,        e.pc);
        chk("sb_instrd",   bus.InstrD,     e.instr);
        chk("sb_pcplus8d", bus.PCPlus8D,   e.p8);
        chk("sb_validd",   {31'h0, bus.ValidD}, {31'h0, e.vld});
        chk("sb_fetchcnt", bus.FetchCount, e.fc);
        chk("sb_stallcnt", bus.StallCount, e.sc);
        m = e;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        bus.PCSrcW  = 1'b1;
        bus.ResultW = tgt;
        cycle();
        idle();
    endtask

    initial begin
        idle();
        bus.InstrF = 32'h0;
        use_const  = 1'b1;
        m          = '0;
        reset      = 1'b1;
        cycle();
        cycle();
        chk("rst_pcf",    bus.PCF,        32'h0);
        chk("rst_instrd", bus.InstrD,     NOP);
        chk("rst_p8",     bus.PCPlus8D,   32'h0);
        chk("rst_valid",  {31'h0, bus.ValidD}, 32'h0);
        chk("rst_fcnt",   bus.FetchCount, 32'h0);
        chk("rst_scnt",   bus.StallCount, 32'h0);
        reset = 1'b0;

        // Sequential fetch of a constant word.
        cycle();
        chk("seq_pc4",    bus.PCF,      32'h4);
        chk("seq_instr",  bus.InstrD,   32'hE280_0001);
        chk("seq_p8_4",   bus.PCPlus8D, 32'h4);
        chk("seq_valid",  {31'h0, bus.ValidD}, 32'h1);
        cycle();
        chk("seq_pc8",    bus.PCF,      32'h8);
        chk("seq_p8_8",   bus.PCPlus8D, 32'h8);
        use_const = 1'b0;

        // Branch and writeback redirect together: branch wins.
        bus.BranchTakenE = 1'b1; bus.ALUResultE = 32'h100;
        bus.PCSrcW       = 1'b1; bus.ResultW    = 32'h200;
        cycle();
        idle();
        chk("br_pc",      bus.PCF,    32'h100);
        chk("br_valid",   {31'h0, bus.ValidD}, 32'h0);
        chk("br_instr",   bus.InstrD, NOP);
        cycle();
        chk("br_tgt_vld", {31'h0, bus.ValidD}, 32'h1);
        chk("br_tgt_ins", bus.InstrD,   instr_at(32'h100));
        chk("br_tgt_p8",  bus.PCPlus8D, 32'h104);

        // Full stall at PCF=C.
        redirect_to(32'h8);
        cycle();
        chk("stl_pre_pc", bus.PCF, 32'hC);
        held_instr = bus.InstrD;
        bus.StallF = 1'b1; bus.StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stl_pc",    bus.PCF,      32'hC);
            chk("stl_instr", bus.InstrD,   held_instr);
            chk("stl_p8",    bus.PCPlus8D, 32'hC);
        end
        idle();
        cycle();
        chk("stl_rel_pc", bus.PCF, 32'h10);

        // Instruction-memory miss at PCF=4.
        redirect_to(32'h4);
        bus.ImemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("miss_pc",    bus.PCF, 32'h4);
            chk("miss_valid", {31'h0, bus.ValidD}, 32'h0);
        end
        idle();
        cycle();
        chk("miss_instr", bus.InstrD,   instr_at(32'h4));
        chk("miss_p8",    bus.PCPlus8D, 32'h8);
        chk("miss_pc8",   bus.PCF,      32'h8);

        // PC wrap-around.
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_pre", bus.PCF, 32'hFFFF_FFFC);
        cycle();
        chk("wrap_pc",  bus.PCF,      32'h0);
        chk("wrap_p8",  bus.PCPlus8D, 32'h0);

        // StallD without StallF, then flush together with stall.
        bus.StallD = 1'b1;
        cycle();
        cycle();
        bus.FlushD = 1'b1;
        cycle();
        chk("flush_stall_vld", {31'h0, bus.ValidD}, 32'h0);
        idle();
        cycle();

        // Randomised traffic, including occasional mid-run reset.
        for (int i = 0; i < 400; i++) begin
            bus.StallF       = ($urandom_range(0, 4) == 0);
            bus.StallD       = ($urandom_range(0, 5) == 0);
            bus.FlushD       = ($urandom_range(0, 9) == 0);
            bus.ImemReady    = ($urandom_range(0, 4) != 0);
            bus.BranchTakenE = ($urandom_range(0, 11) == 0);
            bus.ALUResultE   = $urandom;
            bus.PCSrcW       = ($urandom_range(0, 14) == 0);
            bus.ResultW      = $urandom;
            reset            = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();

        // Reset during a fetch stall.
        redirect_to(32'h40);
        bus.StallF = 1'b1;
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst_stall_pc", bus.PCF, 32'h0);
        reset = 1'b0;
        idle();

        // Counters: 10 valid fetches then 3 stall cycles.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        bus.StallF = 1'b1; bus.StallD = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        idle();
`ifdef ARM_FETCH_PERF_EN
        chk("perf_fetch", bus.FetchCount, 32'd10);
        chk("perf_stall", bus.StallCount, 32'd3);
`else
        chk("perf_fetch_off", bus.FetchCount, 32'd0);
        chk("perf_stall_off", bus.StallCount, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arm_fetch_stage.md
Name: arm_fetch_stage

Overview:
Fetch stage and F/D pipeline register for the pipelined ARM core.
- Owns the PC register and drives the instruction-memory address.
- Captures the fetched word into the decode stage; applies stall, flush and branch redirects from the hazard unit and from the Execute/Writeback stages.
- Delivers InstrD, PCPlus8D (the R15 read value) and ValidD to the decode/controller logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'hE1A0_0000, bubble word (MOV r0,r0) injected into decode on flush or imem miss

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
PCF  out  32  fetch address to instruction memory
InstrF  in  32  instruction word returned for PCF (same cycle)
ImemReady  in  1  InstrF valid this cycle
StallF  in  1  hold PC (hazard unit)
StallD  in  1  hold F/D register (hazard unit)
FlushD  in  1  invalidate F/D register (hazard unit)
BranchTakenE  in  1  early branch resolved taken in Execute
ALUResultE  in  32  branch target from Execute
PCSrcW  in  1  PC write from Writeback
ResultW  in  32  PC value from Writeback
InstrD  out  32  instruction in decode
PCPlus8D  out  32  PC+8 of the decode instruction
ValidD  out  1  InstrD holds a real instruction
FetchCount  out  32  fetched-instruction counter (optional feature)
StallCount  out  32  fetch-stall cycle counter (optional feature)

Behaviour:
- Reset (synchronous, high at posedge): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus8D=0, ValidD=0, counters=0. Reset overrides every other input. Reset mid-operation discards any in-flight redirect.
- PCPlus4F = PCF+4, 32-bit modulo. 32'hFFFF_FFFC wraps to 0 with no flag.
- Next-PC priority, highest first:
  1. BranchTakenE -> ALUResultE
  2. PCSrcW -> ResultW
  3. StallF or !ImemReady -> hold PCF
  4. otherwise -> PCPlus4F
- A redirect overrides StallF and !ImemReady. The PC always loads the redirect target.
- Targets are loaded unmodified; bits [1:0] are not masked.
- F/D register priority, highest first:
  1. FlushD, or a redirect this cycle -> InstrD=NOP_INSTR, ValidD=0, PCPlus8D=0
  2. StallD -> hold all three
  3. !ImemReady -> InstrD=NOP_INSTR, ValidD=0, PCPlus8D unchanged
  4. otherwise -> InstrD=InstrF, PCPlus8D=PCPlus4F, ValidD=1
- FlushD together with StallD: flush wins.
- Latency: one cycle from InstrF to InstrD. A redirect asserted in cycle n gives PCF=target at n+1 and a valid target instruction in decode at n+2 (provided ImemReady=1).
- StallF=0 with StallD=1 is legal: PC advances, F/D holds, and the fetched word is lost. The hazard unit must not issue this combination. The bench checks only that it is deterministic.

Optional Feature:
- Macro: ARM_FETCH_PERF_EN.
- Defined:
  - FetchCount increments on each cycle the F/D register loads ValidD=1.
  - StallCount increments on each cycle with (StallF | !ImemReady) and no redirect.
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Package arm_pkg: NOP_INSTR constant, RESET_PC default, WORD_W=32, PC_INC=4.
- One sub-module, arm_fd_reg: an enable/clear register parameterised by width. It is instantiated for InstrD, PCPlus8D and ValidD; the clear value is supplied per instance.
- The next-PC mux and the PC flop stay in the top module.

Test Plan:
- Reset, then 4 cycles with ImemReady=1 and InstrF=32'hE280_0001 -> PCF = 0, 4, 8, C; from cycle 2 InstrD=E2800001, ValidD=1, PCPlus8D=PCF_prev+4.
- BranchTakenE=1, ALUResultE=32'h100 at PCF=8, with PCSrcW=1, ResultW=32'h200 in the same cycle -> PCF=100 next cycle; ValidD=0 and InstrD=E1A00000 for one cycle.
- StallF=StallD=1 for 3 cycles at PCF=C -> PCF, InstrD and PCPlus8D held constant; release -> PCF=10.
- ImemReady=0 for 2 cycles at PCF=4 -> PCF stays 4; ValidD=0 for 2 cycles; then the instruction at 4 appears with PCPlus8D=8.
- PCF=FFFFFFFC, then advance -> PCF=0 and PCPlus8D=0. Reset asserted during a StallF -> PCF=0 next cycle.
- With ARM_FETCH_PERF_EN defined: 10 valid fetches plus 3 stall cycles -> FetchCount=10, StallCount=3. Without the macro, both counters read 0.
